// File: rtl/vga_clkgen_prog_pkg.sv
// Shared definitions for the VGA DCM_CLKGEN serial programmer:
// FSM states, command opcodes, frame geometry and a frame builder.
package vga_clkgen_prog_pkg;

  localparam int FIELD_W    = 8;
  localparam int FRAME_BITS = 10;
  localparam int DIV_W      = 8;

  // Opcodes that prefix each load frame; both go out LSB first.
  localparam logic [1:0] CMD_LOAD_D = 2'b01;
  localparam logic [1:0] CMD_LOAD_M = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_D,
    ST_GAP1,
    ST_LOAD_M,
    ST_GAP2,
    ST_GO,
    ST_WAIT_LOW,
    ST_WAIT_HIGH
  } prog_state_t;

  // A load frame is the opcode followed by the value, so that bit 0 of the
  // returned vector is the first bit placed on progdata.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [1:0]         cmd,
                                                        input logic [FIELD_W-1:0] value);
    return {value, cmd};
  endfunction

endpackage

// File: rtl/clkgen_prog_div.sv
// Free-running programming-clock divider. progclk toggles every PROG_DIV
// sys_clk cycles; fall_tick marks the sys_clk cycle whose edge drives
// progclk from 1 to 0, so registers updated on it change with progclk's fall.
module clkgen_prog_div
  import vga_clkgen_prog_pkg::*;
#(
  parameter int PROG_DIV = 4
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  output logic progclk,
  output logic fall_tick
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PROG_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             terminal;

  assign terminal  = (div_cnt == DIV_LAST);
  assign fall_tick = terminal & progclk;

  // Count half-periods and flip progclk at each terminal count; reset parks it low.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      div_cnt <= '0;
      progclk <= 1'b0;
    end else if (terminal) begin
      div_cnt <= '0;
      progclk <= ~progclk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/vga_clkgen_prog.sv
// Serial programmer for the VGA pixel-clock DCM_CLKGEN. Sends LOAD_D, LOAD_M
// and GO frames over progclk/progdata/progen, then waits for progdone to
// drop and rise again, reporting done or error back to software.
module vga_clkgen_prog
  import vga_clkgen_prog_pkg::*;
#(
  parameter int PROG_DIV = 4,
  parameter int TIMEOUT  = 4095
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               start,
  input  logic [FIELD_W-1:0] m_minus1,
  input  logic [FIELD_W-1:0] d_minus1,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic               vga_progclk,
  output logic               vga_progdata,
  output logic               vga_progen,
  input  logic               vga_progdone
);

  localparam logic [3:0]  LAST_BIT = 4'(FRAME_BITS - 1);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  prog_state_t state, state_next;

  logic                    fall_tick;
  logic [1:0]              progdone_sync;
  logic                    progdone_s;
  logic [3:0]              bit_cnt, bit_cnt_next;
  logic [15:0]             tmo_cnt, tmo_cnt_next;
  logic [FRAME_BITS-2:0]   shreg, shreg_next;
  logic [FIELD_W-1:0]      m_reg, m_next;
  logic [FIELD_W-1:0]      d_reg, d_next;
  logic                    busy_next, done_next, error_next;
  logic                    progen_next, progdata_next;
  logic [FRAME_BITS-1:0]   d_frame, m_frame;

  clkgen_prog_div #(
    .PROG_DIV (PROG_DIV)
  ) u_div (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .progclk   (vga_progclk),
    .fall_tick (fall_tick)
  );

  assign d_frame    = build_frame(CMD_LOAD_D, d_reg);
  assign m_frame    = build_frame(CMD_LOAD_M, m_reg);
  assign progdone_s = progdone_sync[1];

  // Bring progdone from the progclk domain into sys_clk through two flops.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      progdone_sync <= 2'b00;
    end else begin
      progdone_sync <= {progdone_sync[0], vga_progdone};
    end
  end

  // Register FSM state together with every datapath value it computes.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state        <= ST_IDLE;
      bit_cnt      <= '0;
      tmo_cnt      <= '0;
      shreg        <= '0;
      m_reg        <= '0;
      d_reg        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      vga_progen   <= 1'b0;
      vga_progdata <= 1'b0;
    end else begin
      state        <= state_next;
      bit_cnt      <= bit_cnt_next;
      tmo_cnt      <= tmo_cnt_next;
      shreg        <= shreg_next;
      m_reg        <= m_next;
      d_reg        <= d_next;
      busy         <= busy_next;
      done         <= done_next;
      error        <= error_next;
      vga_progen   <= progen_next;
      vga_progdata <= progdata_next;
    end
  end

  // Sequence the frames: serial lines move only on fall_tick, while the
  // progdone waits are evaluated every cycle so completion is seen promptly.
  always_comb begin
    state_next    = state;
    bit_cnt_next  = bit_cnt;
    tmo_cnt_next  = tmo_cnt;
    shreg_next    = shreg;
    m_next        = m_reg;
    d_next        = d_reg;
    busy_next     = busy;
    done_next     = 1'b0;
    error_next    = 1'b0;
    progen_next   = vga_progen;
    progdata_next = vga_progdata;

    unique case (state)
      ST_IDLE: begin
        if (!busy) begin
          if (start) begin
            if (m_minus1 == '0) begin
              error_next = 1'b1;
            end else begin
              busy_next = 1'b1;
              m_next    = m_minus1;
              d_next    = d_minus1;
            end
          end
        end else if (fall_tick) begin
          state_next    = ST_LOAD_D;
          bit_cnt_next  = '0;
          progen_next   = 1'b1;
          progdata_next = d_frame[0];
          shreg_next    = d_frame[FRAME_BITS-1:1];
        end
      end

      ST_LOAD_D, ST_LOAD_M: begin
        if (fall_tick) begin
          if (bit_cnt == LAST_BIT) begin
            state_next    = (state == ST_LOAD_D) ? ST_GAP1 : ST_GAP2;
            progen_next   = 1'b0;
            progdata_next = 1'b0;
          end else begin
            bit_cnt_next  = bit_cnt + 4'd1;
            progdata_next = shreg[0];
            shreg_next    = {1'b0, shreg[FRAME_BITS-2:1]};
          end
        end
      end

      ST_GAP1: begin
        if (fall_tick) begin
          state_next    = ST_LOAD_M;
          bit_cnt_next  = '0;
          progen_next   = 1'b1;
          progdata_next = m_frame[0];
          shreg_next    = m_frame[FRAME_BITS-1:1];
        end
      end

      ST_GAP2: begin
        if (fall_tick) begin
          state_next    = ST_GO;
          progen_next   = 1'b1;
          progdata_next = 1'b0;
        end
      end

      ST_GO: begin
        if (fall_tick) begin
          state_next   = ST_WAIT_LOW;
          tmo_cnt_next = '0;
          progen_next  = 1'b0;
        end
      end

      ST_WAIT_LOW: begin
        if (!progdone_s) begin
          state_next   = ST_WAIT_HIGH;
          tmo_cnt_next = '0;
        end else if (fall_tick) begin
          if (tmo_cnt == TMO_LAST) begin
            state_next  = ST_IDLE;
            busy_next   = 1'b0;
            error_next  = 1'b1;
            progen_next = 1'b0;
          end else begin
            tmo_cnt_next = tmo_cnt + 16'd1;
          end
        end
      end

      ST_WAIT_HIGH: begin
        // A rising progdone beats a timeout landing in the same cycle.
        if (progdone_s) begin
          state_next = ST_IDLE;
          busy_next  = 1'b0;
          done_next  = 1'b1;
        end else if (fall_tick) begin
          if (tmo_cnt == TMO_LAST) begin
            state_next  = ST_IDLE;
            busy_next   = 1'b0;
            error_next  = 1'b1;
            progen_next = 1'b0;
          end else begin
            tmo_cnt_next = tmo_cnt + 16'd1;
          end
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_vga_clkgen_prog.sv
// Randomised scoreboard bench for vga_clkgen_prog with a small DCM model.
module tb_vga_clkgen_prog;

  localparam int PROG_DIV  = 2;
  localparam int TIMEOUT   = 16;
  localparam int SEQ_LEN   = 23;
  localparam int KIND_ERR  = 1;
  localparam int KIND_DONE = 2;

  typedef struct {
    logic [31:0] en;
    logic [31:0] dat;
  } frame_t;

  typedef struct {
    int kind;
    int cycle;
  } result_t;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       start     = 1'b0;
  logic [7:0] m_minus1  = 8'h00;
  logic [7:0] d_minus1  = 8'h00;
  logic       busy, done, error;
  logic       vga_progclk, vga_progdata, vga_progen;
  logic       vga_progdone;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int frames_seen = 0;
  int frames_expected = 0;
  int edge_viol = 0;
  bit dcm_respond = 1'b1;

  frame_t  exp_frames[$];
  result_t exp_results[$];

  vga_clkgen_prog #(
    .PROG_DIV (PROG_DIV),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .start        (start),
    .m_minus1     (m_minus1),
    .d_minus1     (d_minus1),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .vga_progclk  (vga_progclk),
    .vga_progdata (vga_progdata),
    .vga_progen   (vga_progen),
    .vga_progdone (vga_progdone)
  );

  initial forever #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Reference: the whole 23-period transaction as a list of (progen, progdata) pairs.
  function automatic void refFrame(input logic [7:0] d, input logic [7:0] m,
                                   output logic [31:0] en, output logic [31:0] dat);
    int dq[$];
    int eq[$];
    dq.push_back(1); dq.push_back(0);
    for (int i = 0; i < 8; i++) dq.push_back(int'((d >> i) & 8'd1));
    for (int i = 0; i < 10; i++) eq.push_back(1);
    dq.push_back(0); eq.push_back(0);
    dq.push_back(1); dq.push_back(1);
    for (int i = 0; i < 8; i++) dq.push_back(int'((m >> i) & 8'd1));
    for (int i = 0; i < 10; i++) eq.push_back(1);
    dq.push_back(0); eq.push_back(0);
    dq.push_back(0); eq.push_back(1);
    en  = '0;
    dat = '0;
    for (int i = 0; i < dq.size(); i++) begin
      en[i]  = (eq[i] != 0);
      dat[i] = (dq[i] != 0);
    end
  endfunction

  // DCM model: progdone drops on the first enabled bit and rises 3 progclk periods after GO.
  int dcm_en_cnt = 0;
  int dcm_post = 0;
  always @(posedge vga_progclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vga_progdone <= 1'b1;
      dcm_en_cnt   <= 0;
      dcm_post     <= 0;
    end else if (vga_progen) begin
      if (dcm_en_cnt == 0 && dcm_respond) vga_progdone <= 1'b0;
      dcm_en_cnt <= dcm_en_cnt + 1;
      if (dcm_en_cnt == 20) dcm_post <= 1;
    end else if (dcm_post != 0) begin
      if (dcm_post == 3) begin
        if (dcm_respond) vga_progdone <= 1'b1;
        dcm_post   <= 0;
        dcm_en_cnt <= 0;
      end else begin
        dcm_post <= dcm_post + 1;
      end
    end
  end

  // Monitor: samples on the falling sys_clk edge, collects frames at progclk rises,
  // checks edge alignment and pops expected done/error results.
  bit          collecting = 0;
  int          idx = 0;
  int          last_rise = -1;
  bit          pulse_prev = 0;
  bit          rst_seen = 1;
  logic        pclk_prev = 0, en_prev = 0, dat_prev = 0;
  logic [31:0] en_v, dat_v;
  frame_t      mf;
  result_t     mr;
  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      collecting = 0;
      idx        = 0;
      last_rise  = -1;
      pulse_prev = 0;
      rst_seen   = 1;
    end else begin
      if (vga_progclk && !pclk_prev) begin
        if (collecting && last_rise >= 0)
          checkOutput("progclk_period", 32'(cyc - last_rise), 32'(2 * PROG_DIV));
        last_rise = cyc;
        if (!collecting && vga_progen) begin
          collecting = 1;
          idx   = 0;
          en_v  = '0;
          dat_v = '0;
        end
        if (collecting) begin
          en_v[idx]  = vga_progen;
          dat_v[idx] = vga_progdata;
          idx++;
          if (idx == SEQ_LEN) begin
            collecting = 0;
            frames_seen++;
            if (exp_frames.size() == 0) begin
              checkOutput("unexpected_frame", 32'd1, 32'd0);
            end else begin
              mf = exp_frames.pop_front();
              checkOutput("frame_progen", en_v, mf.en);
              checkOutput("frame_progdata", dat_v & mf.en, mf.dat & mf.en);
            end
          end
        end
      end
      if (!rst_seen && (vga_progen !== en_prev || vga_progdata !== dat_prev) && !(pclk_prev && !vga_progclk))
        edge_viol++;
      if (pulse_prev) checkOutput("pulse_width", {30'b0, done, error}, 32'd0);
      pulse_prev = 0;
      if (done || error) begin
        if (exp_results.size() == 0) begin
          checkOutput("unexpected_result", {30'b0, done, error}, 32'd0);
        end else begin
          mr = exp_results.pop_front();
          checkOutput("result_kind", {30'b0, done, error}, 32'(mr.kind));
          if (mr.cycle >= 0) checkOutput("result_latency", 32'(cyc), 32'(mr.cycle));
          checkOutput("busy_with_result", {31'b0, busy}, 32'd0);
        end
        pulse_prev = 1;
      end
      rst_seen = 0;
    end
    pclk_prev = vga_progclk;
    en_prev   = vga_progen;
    dat_prev  = vga_progdata;
  end

  // Issue one start request and push the expected responses.
  task automatic applyStimulus(input logic [7:0] d, input logic [7:0] m, input bit respond);
    frame_t  f;
    result_t r;
    dcm_respond = respond;
    @(posedge sys_clk); #1;
    d_minus1 = d;
    m_minus1 = m;
    start    = 1'b1;
    if (m == 8'h00) begin
      r.kind  = KIND_ERR;
      r.cycle = cyc + 1;
    end else begin
      refFrame(d, m, f.en, f.dat);
      exp_frames.push_back(f);
      frames_expected++;
      r.kind  = respond ? KIND_DONE : KIND_ERR;
      r.cycle = -1;
    end
    exp_results.push_back(r);
    @(posedge sys_clk); #1;
    start = 1'b0;
  endtask

  task automatic waitIdle();
    int n = 0;
    while ((busy || exp_frames.size() != 0 || exp_results.size() != 0) && n < 2000) begin
      @(negedge sys_clk);
      n++;
    end
    if (n >= 2000) begin
      checkOutput("idle_wait_expired", 32'd1, 32'd0);
      exp_frames.delete();
      exp_results.delete();
    end
    repeat (3) @(negedge sys_clk);
  endtask

  task automatic pokeDuringLoadM();
    int n = 0;
    while (!(collecting && idx >= 13) && n < 500) begin
      @(posedge sys_clk);
      n++;
    end
    checkOutput("reached_load_m", {31'b0, (n < 500)}, 32'd1);
    #1;
    d_minus1 = ~d_minus1;
    m_minus1 = 8'hA5;
    start    = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b0;
  endtask

  task automatic resetMidLoad();
    int n = 0;
    applyStimulus(8'h09, 8'(($urandom_range(255, 1))), 1'b1);
    while (!(collecting && idx >= 6) && n < 500) begin
      @(posedge sys_clk);
      n++;
    end
    #1;
    checkOutput("pre_reset_lines", {28'b0, vga_progen, vga_progdata, vga_progclk, busy}, 32'hF);
    sys_rst_n = 1'b0;
    #1;
    checkOutput("async_reset_lines", {28'b0, vga_progen, vga_progdata, vga_progclk, busy}, 32'h0);
    exp_frames.delete();
    exp_results.delete();
    frames_expected--;
    repeat (3) @(negedge sys_clk);
    checkOutput("reset_hold_progclk", {31'b0, vga_progclk}, 32'd0);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit quiet_viol;
    $display("[TB] starting vga_clkgen_prog bench");
    repeat (3) @(negedge sys_clk);
    checkOutput("reset_outputs", {26'b0, busy, done, error, vga_progen, vga_progdata, vga_progclk}, 32'd0);
    sys_rst_n = 1'b1;
    repeat (4) @(negedge sys_clk);

    applyStimulus(8'h09, 8'h0C, 1'b1);
    waitIdle();

    applyStimulus(8'($urandom), 8'h00, 1'b1);
    quiet_viol = 0;
    repeat (8) begin
      @(negedge sys_clk);
      if (busy || vga_progen) quiet_viol = 1;
    end
    checkOutput("reject_quiet", {31'b0, quiet_viol}, 32'd0);
    waitIdle();

    applyStimulus(8'($urandom), 8'($urandom_range(255, 1)), 1'b0);
    waitIdle();
    applyStimulus(8'($urandom), 8'($urandom_range(255, 1)), 1'b1);
    waitIdle();

    applyStimulus(8'($urandom), 8'($urandom_range(255, 1)), 1'b1);
    pokeDuringLoadM();
    waitIdle();

    resetMidLoad();
    applyStimulus(8'($urandom), 8'($urandom_range(255, 1)), 1'b1);
    waitIdle();

    for (int k = 0; k < 4; k++) begin
      applyStimulus(8'($urandom), 8'($urandom_range(255, 1)), 1'b1);
      waitIdle();
    end

    checkOutput("edge_alignment", 32'(edge_viol), 32'd0);
    checkOutput("frame_count", 32'(frames_seen), 32'(frames_expected));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
